// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with locked bursts feeding one registered valid/ready output.
module rr_arbiter4 #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [3:0]   lock,
    input  logic [n-1:0] d0,
    input  logic [n-1:0] d1,
    input  logic [n-1:0] d2,
    input  logic [n-1:0] d3,
    output logic [3:0]   ack,
    output logic [n-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   sel,
    output logic [3:0]   grant
);
    typedef enum logic {IDLE, LOCKED} state_e;
    state_e       state_q, state_d;
    logic [1:0]   last_q, last_d, sel_q, sel_d, w;
    logic [3:0]   grant_q, grant_d;
    logic [n-1:0] data_q, data_d, w_data;
    logic         valid_q, valid_d, space, hit, accept;
    assign space  = !valid_q || out_ready;
    assign accept = space && hit;
    assign ack    = accept ? 4'b0001 << w : 4'b0000;
    assign w_data = w == 2'd0 ? d0 : w == 2'd1 ? d1 : w == 2'd2 ? d2 : d3;
    // Scan descending so the nearest requester after last_q is the one left in w.
    always_comb begin
        hit = 1'b0;
        w   = last_q;
        if (state_q == LOCKED) hit = req[last_q];
        else
            for (int k = 4; k >= 1; k--)
                if (req[last_q + 2'(k)]) begin
                    hit = 1'b1;
                    w   = last_q + 2'(k);
                end
    end
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = w_data;
            sel_d   = w;
            last_d  = w;
            state_d = lock[w] ? LOCKED : IDLE;
            grant_d = lock[w] ? 4'b0001 << w : 4'b0000;
        end else if (space) begin
            valid_d = 1'b0;
            state_d = IDLE;
            grant_d = 4'b0000;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign sel       = sel_q;
    assign grant     = grant_q;
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed vector table plus a hand-written async-reset sequence for rr_arbiter4.
module tb_rr_arbiter4;
    logic        clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0, out_valid;
    logic [3:0]  req = '0, lock = '0, ack, grant;
    logic [31:0] d0 = 32'hA0, d1 = 32'hA1, d2 = 32'hA2, d3 = 32'hA3, out_data;
    logic [1:0]  sel;
    int total = 0, bad = 0;

    typedef struct {
        logic [3:0]  req, lock;
        logic        rdy;
        logic [3:0]  ack;
        logic        v;
        logic [31:0] data;
        logic [1:0]  sel;
        logic [3:0]  g;
    } vec_t;
    vec_t vq[$];

    rr_arbiter4 #(.n(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .ack(ack), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .sel(sel), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] l, input logic rd,
                                input logic [3:0] a, input logic v, input logic [31:0] dt,
                                input logic [1:0] s, input logic [3:0] g);
        vec_t x;
        x.req = r; x.lock = l; x.rdy = rd; x.ack = a; x.v = v; x.data = dt; x.sel = s; x.g = g;
        return x;
    endfunction

    initial begin
        // full rotation from reset, last starts at 3
        vq.push_back(mk(4'b1111, 4'b0000, 1, 4'b0001, 1, 32'hA0, 0, 4'b0000));
        vq.push_back(mk(4'b1111, 4'b0000, 1, 4'b0010, 1, 32'hA1, 1, 4'b0000));
        vq.push_back(mk(4'b1111, 4'b0000, 1, 4'b0100, 1, 32'hA2, 2, 4'b0000));
        vq.push_back(mk(4'b1111, 4'b0000, 1, 4'b1000, 1, 32'hA3, 3, 4'b0000));
        vq.push_back(mk(4'b1111, 4'b0000, 1, 4'b0001, 1, 32'hA0, 0, 4'b0000));
        // backpressure on requester 2, then drain+accept, then idle bubble
        vq.push_back(mk(4'b0100, 4'b0000, 1, 4'b0100, 1, 32'hA2, 2, 4'b0000));
        vq.push_back(mk(4'b0100, 4'b0000, 0, 4'b0000, 1, 32'hA2, 2, 4'b0000));
        vq.push_back(mk(4'b0100, 4'b0000, 0, 4'b0000, 1, 32'hA2, 2, 4'b0000));
        vq.push_back(mk(4'b0100, 4'b0000, 0, 4'b0000, 1, 32'hA2, 2, 4'b0000));
        vq.push_back(mk(4'b0100, 4'b0000, 1, 4'b0100, 1, 32'hA2, 2, 4'b0000));
        vq.push_back(mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 32'hA2, 2, 4'b0000));
        // move last to 0, then locked 3-beat burst by requester 1
        vq.push_back(mk(4'b0001, 4'b0000, 1, 4'b0001, 1, 32'hA0, 0, 4'b0000));
        vq.push_back(mk(4'b1111, 4'b0010, 1, 4'b0010, 1, 32'hA1, 1, 4'b0010));
        vq.push_back(mk(4'b1111, 4'b0010, 1, 4'b0010, 1, 32'hA1, 1, 4'b0010));
        vq.push_back(mk(4'b1111, 4'b0000, 1, 4'b0010, 1, 32'hA1, 1, 4'b0000));
        vq.push_back(mk(4'b1111, 4'b0000, 1, 4'b0100, 1, 32'hA2, 2, 4'b0000));
        // locked owner 3 drops req: one empty cycle, then 0 wins
        vq.push_back(mk(4'b1000, 4'b1000, 1, 4'b1000, 1, 32'hA3, 3, 4'b1000));
        vq.push_back(mk(4'b0001, 4'b1000, 1, 4'b0000, 0, 32'hA3, 3, 4'b0000));
        vq.push_back(mk(4'b0001, 4'b0000, 1, 4'b0001, 1, 32'hA0, 0, 4'b0000));
        // alternation between 1 and 3
        vq.push_back(mk(4'b1010, 4'b0000, 1, 4'b0010, 1, 32'hA1, 1, 4'b0000));
        vq.push_back(mk(4'b1010, 4'b0000, 1, 4'b1000, 1, 32'hA3, 3, 4'b0000));
        vq.push_back(mk(4'b1010, 4'b0000, 1, 4'b0010, 1, 32'hA1, 1, 4'b0000));
        vq.push_back(mk(4'b1010, 4'b0000, 1, 4'b1000, 1, 32'hA3, 3, 4'b0000));

        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vq[i]) begin
            req = vq[i].req; lock = vq[i].lock; out_ready = vq[i].rdy;
            #1;
            chk($sformatf("v%0d_ack", i), 32'(ack), 32'(vq[i].ack));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vq[i].v));
            chk($sformatf("v%0d_data", i), out_data, vq[i].data);
            chk($sformatf("v%0d_sel", i), 32'(sel), 32'(vq[i].sel));
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vq[i].g));
            @(negedge clk);
        end

        // lock requester 2, then reset asynchronously while its word is held
        req = 4'b0100; lock = 4'b0100; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("lk2_grant", 32'(grant), 32'b0100);
        chk("lk2_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; req = 4'b1111; lock = 4'b0000; out_ready = 1'b1;
        #1;
        chk("post_rst_ack", 32'(ack), 32'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_sel", 32'(sel), 32'd0);
        chk("post_rst_data", out_data, 32'hA0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
